hp_burst_responder: RTL and testbench
=====================================

# hp_burst_responder

AXI4 slave responder for the 128-bit HP burst interface, backed by an internal on-chip memory. It is the far end of the benchmark kernel's HP master port: it accepts INCR write bursts (AW/W/B) and read bursts (AR/R) and stores or returns data beat by beat. It gives the kernel's write and read benchmark modes a self-contained target for simulation and on-chip loopback without the PS memory path.

## Interface
- HP_ADDR_WIDTH, 48, AW/AR address width
- HP_DATA_WIDTH, 128, data width; fixed 16 B per beat
- MEM_DEPTH_LOG2, 10, log2 of memory entries (default 1024 x 16 B = 16 KB)

Clock is `clk`. Reset is `rstn`: asynchronous, active-low.

- clk  in  1  clock
- rstn  in  1  async active-low reset
- hp_awaddr / hp_awlen / hp_awsize / hp_awburst  in  HP_ADDR_WIDTH/8/3/2  write address channel
- hp_awvalid in 1, hp_awready out 1  AW handshake
- hp_wdata / hp_wstrb / hp_wlast  in  HP_DATA_WIDTH/HP_DATA_WIDTH/8/1  write data
- hp_wvalid in 1, hp_wready out 1  W handshake
- hp_bresp out 2, hp_bvalid out 1, hp_bready in 1  write response
- hp_araddr / hp_arlen / hp_arsize / hp_arburst  in  HP_ADDR_WIDTH/8/3/2  read address channel
- hp_arvalid in 1, hp_arready out 1  AR handshake
- hp_rdata out HP_DATA_WIDTH, hp_rresp out 2, hp_rlast out 1, hp_rvalid out 1, hp_rready in 1  read data

## Operation
- Memory: MEM_DEPTH_LOG2 entries x 128 b; contents not reset. Entry index = addr[4 +: MEM_DEPTH_LOG2]; addr[3:0] ignored.
- awsize/arsize and awburst/arburst are ignored: every burst is treated as INCR, 16 B/beat, awlen+1 (resp. arlen+1) beats, index +1 per beat, wrapping modulo depth.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: hp_awready=1. On AW handshake, latch index and awlen, clear beat count and error flag.
  - W_DATA: hp_wready=1. Each W handshake writes the bytes enabled by wstrb and advances index/count. Error flag is set if wlast=1 on a beat other than beat awlen, or wlast=0 on beat awlen. Beat count from awlen is authoritative: exactly awlen+1 beats are consumed regardless of wlast.
  - W_RESP: hp_bvalid=1, hp_bresp = 2 (SLVERR) if error flag else 0. Held until hp_bready.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: hp_arready=1. On AR handshake, latch index and arlen.
  - R_DATA: hp_rvalid=1, hp_rdata=mem[index], hp_rlast=1 only on beat arlen, hp_rresp=0. Advance on each R handshake. After the last beat is accepted, return to R_IDLE.
- Read and write FSMs are independent and run concurrently. A read of the entry being written in the same cycle returns the pre-write data.
- hp_rdata, hp_rlast, hp_rresp are 0 whenever hp_rvalid=0.

## Timing
- Reset values: hp_awready=1, hp_arready=1, hp_wready=0, hp_bvalid=0, hp_bresp=0, hp_rvalid=0, hp_rlast=0, hp_rresp=0, hp_rdata=0. Both FSMs go to their IDLE states.
- AW accepted in cycle N: hp_wready=1 from N+1. W beats arriving before AW are stalled.
- W throughput is 1 beat/cycle. Last beat accepted in cycle M: hp_bvalid=1 from M+1. B handshake in cycle K: hp_awready=1 in K+1.
- AR accepted in cycle N: first hp_rvalid in N+1. Throughput is 1 beat/cycle while hp_rready=1. hp_rdata and hp_rlast stay stable while hp_rvalid=1 and hp_rready=0. hp_arready=1 the cycle after the last R handshake.
- Only one outstanding burst per direction is supported. A 256-beat write completes in 258 cycles plus B wait.
- Reset asserted mid-burst: all outputs go to reset values asynchronously. The partial burst is abandoned; memory keeps the beats already written.

## Configuration
- HP_RESP_RANGE_CHECK_EN defined:
  - Any beat whose address bits above [4+MEM_DEPTH_LOG2-1] are nonzero is out of range.
  - Out-of-range write beats are dropped, and bresp=3 (DECERR) takes priority over SLVERR.
  - Out-of-range read beats return hp_rdata=0 with hp_rresp=3.
  - The range check tracks the full running address, so a burst that crosses the top of memory errors on the overflowing beats only.
- HP_RESP_RANGE_CHECK_EN not defined: upper address bits are ignored and accesses alias modulo memory size; bresp is only ever 0 or 2, and rresp is always 0.

## Test plan
- Full-burst round trip: write awaddr=0, awlen=255, beat i data = {4{i}}, wstrb all ones, correct wlast; then read araddr=0, arlen=255 with rready=1. Expect bresp=0, beat i = {4{i}}, rlast only on beat 255, rresp=0, 256 consecutive rvalid cycles.
- Partial strobe: prefill entry 1 with zero, then single-beat write awaddr=0x10, awlen=0, wdata all 0xFF, wstrb=0x000F. Read back expects 0x0000..._FFFFFFFF.
- wlast error: awlen=7 with wlast on beat 3 and not on beat 7. Expect all 8 beats consumed and written, and bresp=2 one cycle after beat 8.
- Read backpressure: rready toggles pseudo-randomly over a 256-beat read. Expect rdata/rlast stable while stalled, order preserved, exactly 256 handshakes.
- Concurrency and reset: write burst at 0x1000 concurrent with read burst at 0x0 both complete correctly. Then assert rstn low mid-burst: expect reset output values, and a following 4-beat write/read at 0x2000 succeeds.
- Range check: awaddr = 1<<(4+MEM_DEPTH_LOG2), awlen=0, then read the same address. With the macro: bresp=3, rresp=3, rdata=0, entry 0 unchanged. Without it: bresp=0, and entry 0 holds the written data.

Source files
------------

// File: rtl/hp_burst_responder.sv
// AXI4 INCR burst slave over a 128-bit on-chip memory, independent read/write FSMs.
// Define HP_RESP_RANGE_CHECK_EN to flag beats above the memory size as DECERR.
module hp_burst_responder #(
    parameter int HP_ADDR_WIDTH  = 48,
    parameter int HP_DATA_WIDTH  = 128,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [HP_ADDR_WIDTH-1:0]   hp_awaddr,
    input  logic [7:0]                 hp_awlen,
    input  logic [2:0]                 hp_awsize,
    input  logic [1:0]                 hp_awburst,
    input  logic                       hp_awvalid,
    output logic                       hp_awready,
    input  logic [HP_DATA_WIDTH-1:0]   hp_wdata,
    input  logic [HP_DATA_WIDTH/8-1:0] hp_wstrb,
    input  logic                       hp_wlast,
    input  logic                       hp_wvalid,
    output logic                       hp_wready,
    output logic [1:0]                 hp_bresp,
    output logic                       hp_bvalid,
    input  logic                       hp_bready,
    input  logic [HP_ADDR_WIDTH-1:0]   hp_araddr,
    input  logic [7:0]                 hp_arlen,
    input  logic [2:0]                 hp_arsize,
    input  logic [1:0]                 hp_arburst,
    input  logic                       hp_arvalid,
    output logic                       hp_arready,
    output logic [HP_DATA_WIDTH-1:0]   hp_rdata,
    output logic [1:0]                 hp_rresp,
    output logic                       hp_rlast,
    output logic                       hp_rvalid,
    input  logic                       hp_rready
);
    localparam int BAW   = HP_ADDR_WIDTH - 4;
    localparam int NB    = HP_DATA_WIDTH / 8;
    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e           w_state_q, w_state_d;
    logic [BAW-1:0]     w_addr_q, w_addr_d;
    logic [7:0]         w_len_q, w_len_d;
    logic [7:0]         w_cnt_q, w_cnt_d;
    logic               w_err_q, w_err_d;
    logic               w_dec_q, w_dec_d;
    r_state_e           r_state_q, r_state_d;
    logic [BAW-1:0]     r_addr_q, r_addr_d;
    logic [7:0]         r_len_q, r_len_d;
    logic [7:0]         r_cnt_q, r_cnt_d;

    logic [HP_DATA_WIDTH-1:0] mem [DEPTH];
    logic [HP_DATA_WIDTH-1:0] r_word;
    logic mem_we;
    logic w_oor, r_oor;
    logic w_last_beat, r_last_beat;
    logic unused_ok;

    // Beat addresses are kept at full width so a burst can cross the top of memory.
`ifdef HP_RESP_RANGE_CHECK_EN
    assign w_oor = |w_addr_q[BAW-1:MEM_DEPTH_LOG2];
    assign r_oor = |r_addr_q[BAW-1:MEM_DEPTH_LOG2];
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    assign unused_ok = ^{hp_awaddr[3:0], hp_awsize, hp_awburst,
                         hp_araddr[3:0], hp_arsize, hp_arburst,
                         w_addr_q[BAW-1:MEM_DEPTH_LOG2],
                         r_addr_q[BAW-1:MEM_DEPTH_LOG2]};

    always_comb begin
        w_state_d   = w_state_q;
        w_addr_d    = w_addr_q;
        w_len_d     = w_len_q;
        w_cnt_d     = w_cnt_q;
        w_err_d     = w_err_q;
        w_dec_d     = w_dec_q;
        mem_we      = 1'b0;
        hp_awready  = 1'b0;
        hp_wready   = 1'b0;
        hp_bvalid   = 1'b0;
        hp_bresp    = 2'b00;
        w_last_beat = (w_cnt_q == w_len_q);
        unique case (w_state_q)
            W_IDLE: begin
                hp_awready = 1'b1;
                if (hp_awvalid) begin
                    w_state_d = W_DATA;
                    w_addr_d  = hp_awaddr[HP_ADDR_WIDTH-1:4];
                    w_len_d   = hp_awlen;
                    w_cnt_d   = 8'd0;
                    w_err_d   = 1'b0;
                    w_dec_d   = 1'b0;
                end
            end
            W_DATA: begin
                hp_wready = 1'b1;
                if (hp_wvalid) begin
                    mem_we   = !w_oor;
                    w_dec_d  = w_dec_q | w_oor;
                    w_err_d  = w_err_q | (hp_wlast != w_last_beat);
                    w_addr_d = w_addr_q + BAW'(1);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (w_last_beat) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                hp_bvalid = 1'b1;
                hp_bresp  = w_dec_q ? 2'b11 : (w_err_q ? 2'b10 : 2'b00);
                if (hp_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Combinational read port: a same-cycle write lands after the edge, so reads see old data.
    always_comb begin
        r_state_d   = r_state_q;
        r_addr_d    = r_addr_q;
        r_len_d     = r_len_q;
        r_cnt_d     = r_cnt_q;
        hp_arready  = 1'b0;
        hp_rvalid   = 1'b0;
        hp_rdata    = '0;
        hp_rlast    = 1'b0;
        hp_rresp    = 2'b00;
        r_word      = mem[r_addr_q[MEM_DEPTH_LOG2-1:0]];
        r_last_beat = (r_cnt_q == r_len_q);
        unique case (r_state_q)
            R_IDLE: begin
                hp_arready = 1'b1;
                if (hp_arvalid) begin
                    r_state_d = R_DATA;
                    r_addr_d  = hp_araddr[HP_ADDR_WIDTH-1:4];
                    r_len_d   = hp_arlen;
                    r_cnt_d   = 8'd0;
                end
            end
            R_DATA: begin
                hp_rvalid = 1'b1;
                hp_rdata  = r_oor ? '0 : r_word;
                hp_rresp  = r_oor ? 2'b11 : 2'b00;
                hp_rlast  = r_last_beat;
                if (hp_rready) begin
                    if (r_last_beat) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d = r_addr_q + BAW'(1);
                        r_cnt_d  = r_cnt_q + 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (hp_wstrb[b]) begin
                    mem[w_addr_q[MEM_DEPTH_LOG2-1:0]][b*8 +: 8] <= hp_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            w_dec_q   <= 1'b0;
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            w_dec_q   <= w_dec_d;
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
        end
    end
endmodule

// File: tb/tb_hp_burst_responder.sv
// Random AXI burst traffic against a shadow-memory model of hp_burst_responder.
// Expected R beats and B responses are queued and compared every clock.
module tb_hp_burst_responder;
    localparam int AW    = 48;
    localparam int DW    = 128;
    localparam int DL    = 10;
    localparam int DEPTH = 1 << DL;
    localparam int NB    = DW / 8;
`ifdef HP_RESP_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] hp_awaddr = '0, hp_araddr = '0;
    logic [7:0]    hp_awlen = '0, hp_arlen = '0;
    logic [2:0]    hp_awsize = '0, hp_arsize = '0;
    logic [1:0]    hp_awburst = '0, hp_arburst = '0;
    logic          hp_awvalid = 1'b0, hp_arvalid = 1'b0;
    logic          hp_awready, hp_arready;
    logic [DW-1:0] hp_wdata = '0;
    logic [NB-1:0] hp_wstrb = '0;
    logic          hp_wlast = 1'b0, hp_wvalid = 1'b0, hp_wready;
    logic [1:0]    hp_bresp;
    logic          hp_bvalid, hp_bready = 1'b0;
    logic [DW-1:0] hp_rdata;
    logic [1:0]    hp_rresp;
    logic          hp_rlast, hp_rvalid, hp_rready = 1'b0;

    hp_burst_responder dut (
        .clk(clk), .rstn(rstn),
        .hp_awaddr(hp_awaddr), .hp_awlen(hp_awlen), .hp_awsize(hp_awsize),
        .hp_awburst(hp_awburst), .hp_awvalid(hp_awvalid), .hp_awready(hp_awready),
        .hp_wdata(hp_wdata), .hp_wstrb(hp_wstrb), .hp_wlast(hp_wlast),
        .hp_wvalid(hp_wvalid), .hp_wready(hp_wready),
        .hp_bresp(hp_bresp), .hp_bvalid(hp_bvalid), .hp_bready(hp_bready),
        .hp_araddr(hp_araddr), .hp_arlen(hp_arlen), .hp_arsize(hp_arsize),
        .hp_arburst(hp_arburst), .hp_arvalid(hp_arvalid), .hp_arready(hp_arready),
        .hp_rdata(hp_rdata), .hp_rresp(hp_rresp), .hp_rlast(hp_rlast),
        .hp_rvalid(hp_rvalid), .hp_rready(hp_rready)
    );

    int chk_cnt = 0;
    int pass_cnt = 0;
    int r_hs_cnt = 0;
    bit chk_en = 1'b1;

    logic [DW-1:0] mdl [DEPTH];
    logic [DW-1:0] wd [256];
    logic [NB-1:0] ws [256];
    logic          wl [256];
    logic [DW-1:0] exp_rd_q [$];
    logic          exp_rl_q [$];
    logic [1:0]    exp_rr_q [$];
    logic [1:0]    exp_b_q [$];

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Per-cycle compare of R and B channels against the queued predictions.
    always @(negedge clk) begin
        if (rstn && chk_en) begin
            if (hp_rvalid) begin
                if (exp_rd_q.size() == 0) begin
                    check("r_spurious", DW'(hp_rvalid), DW'(0));
                end else begin
                    check("rdata", hp_rdata, exp_rd_q[0]);
                    check("rlast", DW'(hp_rlast), DW'(exp_rl_q[0]));
                    check("rresp", DW'(hp_rresp), DW'(exp_rr_q[0]));
                    if (hp_rready) begin
                        void'(exp_rd_q.pop_front());
                        void'(exp_rl_q.pop_front());
                        void'(exp_rr_q.pop_front());
                        r_hs_cnt++;
                    end
                end
            end else begin
                check("r_idle_zero",
                      hp_rdata | DW'(hp_rlast) | DW'(hp_rresp), DW'(0));
            end
            if (hp_bvalid) begin
                if (exp_b_q.size() == 0) begin
                    check("b_spurious", DW'(hp_bvalid), DW'(0));
                end else begin
                    check("bresp", DW'(hp_bresp), DW'(exp_b_q[0]));
                    if (hp_bready) void'(exp_b_q.pop_front());
                end
            end else begin
                check("b_idle_zero", DW'(hp_bresp), DW'(0));
            end
        end
    end

    task automatic wr_burst(input logic [AW-1:0] addr, input int len,
                            input bit gaps, output logic [1:0] bresp);
        logic [AW-5:0] ba;
        bit err, dec, oor;
        int n;
        err = 1'b0;
        dec = 1'b0;
        @(posedge clk); #1;
        hp_awaddr  = addr;
        hp_awlen   = 8'(len);
        hp_awsize  = 3'($urandom);
        hp_awburst = 2'($urandom);
        hp_awvalid = 1'b1;
        hp_wdata   = wd[0];
        hp_wstrb   = ws[0];
        hp_wlast   = wl[0];
        hp_wvalid  = 1'b1;
        @(negedge clk);
        check("wready_before_aw", DW'(hp_wready), DW'(0));
        n = 0;
        while (!hp_awready && n < 300) begin @(negedge clk); n++; end
        check("aw_wait", DW'(hp_awready), DW'(1));
        @(posedge clk); #1;
        hp_awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            hp_wdata  = wd[i];
            hp_wstrb  = ws[i];
            hp_wlast  = wl[i];
            hp_wvalid = 1'b1;
            if (gaps && i > 0 && $urandom_range(3) == 0) begin
                hp_wvalid = 1'b0;
                @(posedge clk); #1;
                hp_wvalid = 1'b1;
            end
            @(negedge clk);
            if (i == 0) check("wready_after_aw", DW'(hp_wready), DW'(1));
            n = 0;
            while (!hp_wready && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) check("w_timeout", DW'(hp_wready), DW'(1));
            @(posedge clk);
            ba  = addr[AW-1:4] + (AW-4)'(i);
            oor = RC && ((ba >> DL) != 0);
            if (!oor) begin
                for (int b = 0; b < NB; b++)
                    if (ws[i][b]) mdl[ba[DL-1:0]][b*8 +: 8] = wd[i][b*8 +: 8];
            end
            dec = dec | oor;
            err = err | (wl[i] != (i == len));
            #1;
        end
        hp_wvalid = 1'b0;
        hp_wlast  = 1'b0;
        bresp = dec ? 2'd3 : (err ? 2'd2 : 2'd0);
        exp_b_q.push_back(bresp);
        @(negedge clk);
        check("bvalid_after_last", DW'(hp_bvalid), DW'(1));
        n = 0;
        do begin
            @(posedge clk); #1;
            hp_bready = 1'($urandom_range(1));
            @(negedge clk);
            n++;
        end while (!(hp_bvalid && hp_bready) && n < 100);
        @(posedge clk); #1;
        hp_bready = 1'b0;
        @(negedge clk);
        check("awready_after_b", DW'(hp_awready), DW'(1));
        check("bvalid_after_b", DW'(hp_bvalid), DW'(0));
    endtask

    task automatic rd_burst(input logic [AW-1:0] addr, input int len, input bit bp);
        logic [AW-5:0] ba;
        int n, start, cyc;
        for (int i = 0; i <= len; i++) begin
            ba = addr[AW-1:4] + (AW-4)'(i);
            if (RC && ((ba >> DL) != 0)) begin
                exp_rd_q.push_back('0);
                exp_rr_q.push_back(2'd3);
            end else begin
                exp_rd_q.push_back(mdl[ba[DL-1:0]]);
                exp_rr_q.push_back(2'd0);
            end
            exp_rl_q.push_back(i == len);
        end
        @(posedge clk); #1;
        hp_araddr  = addr;
        hp_arlen   = 8'(len);
        hp_arsize  = 3'($urandom);
        hp_arburst = 2'($urandom);
        hp_arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!hp_arready && n < 300) begin @(negedge clk); n++; end
        check("ar_wait", DW'(hp_arready), DW'(1));
        @(posedge clk); #1;
        hp_arvalid = 1'b0;
        hp_rready  = bp ? 1'($urandom_range(1)) : 1'b1;
        start = r_hs_cnt;
        @(negedge clk);
        check("rvalid_after_ar", DW'(hp_rvalid), DW'(1));
        cyc = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (r_hs_cnt - start >= len + 1 || cyc > 3000) break;
            hp_rready = bp ? 1'($urandom_range(1)) : 1'b1;
        end
        hp_rready = 1'b0;
        check("r_beats", DW'(r_hs_cnt - start), DW'(len + 1));
        if (!bp) check("r_cycles", DW'(cyc), DW'(len + 1));
        @(negedge clk);
        check("arready_after_last", DW'(hp_arready), DW'(1));
        check("rvalid_after_last", DW'(hp_rvalid), DW'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, DW'(hp_awready), DW'(1));
        check({tag, "_arready"}, DW'(hp_arready), DW'(1));
        check({tag, "_wready"}, DW'(hp_wready), DW'(0));
        check({tag, "_bvalid"}, DW'(hp_bvalid), DW'(0));
        check({tag, "_bresp"}, DW'(hp_bresp), DW'(0));
        check({tag, "_rvalid"}, DW'(hp_rvalid), DW'(0));
        check({tag, "_rlast"}, DW'(hp_rlast), DW'(0));
        check({tag, "_rresp"}, DW'(hp_rresp), DW'(0));
        check({tag, "_rdata"}, hp_rdata, DW'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] br;
        logic [AW-1:0] a;
        int len, n;
        bit hs;
        #2 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rstn = 1'b1;

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 256; i++) begin
                wd[i] = {$urandom, $urandom, $urandom, $urandom};
                ws[i] = '1;
                wl[i] = (i == 255);
            end
            wr_burst(AW'(k * 4096), 255, 1'b0, br);
        end

        for (int i = 0; i < 256; i++) begin
            wd[i] = {4{32'(i)}};
            ws[i] = '1;
            wl[i] = (i == 255);
        end
        wr_burst('0, 255, 1'b0, br);
        check("model_full_word5", mdl[5], {4{32'd5}});
        rd_burst('0, 255, 1'b0);

        wd[0] = '0; ws[0] = '1; wl[0] = 1'b1;
        wr_burst(AW'(16), 0, 1'b0, br);
        wd[0] = '1; ws[0] = 16'h000F;
        wr_burst(AW'(16), 0, 1'b0, br);
        check("model_partial", mdl[1], 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
        rd_burst(AW'(16), 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            wd[i] = {$urandom, $urandom, $urandom, $urandom};
            ws[i] = '1;
            wl[i] = (i == 3);
        end
        wr_burst(AW'(32'h400), 7, 1'b0, br);
        check("model_wlast_bresp", DW'(br), DW'(2));
        rd_burst(AW'(32'h400), 7, 1'b0);

        rd_burst('0, 255, 1'b1);

        repeat (12) begin
            len = $urandom_range(31);
            a = '0;
            a[4 +: DL] = DL'($urandom);
            a[3:0] = 4'($urandom);
            for (int i = 0; i <= len; i++) begin
                wd[i] = {$urandom, $urandom, $urandom, $urandom};
                ws[i] = NB'($urandom);
                wl[i] = (i == len) ^ ($urandom_range(15) == 0);
            end
            wr_burst(a, len, 1'b1, br);
            rd_burst(a, len, 1'($urandom_range(1)));
        end

        for (int i = 0; i < 32; i++) begin
            wd[i] = {$urandom, $urandom, $urandom, $urandom};
            ws[i] = '1;
            wl[i] = (i == 31);
        end
        fork
            wr_burst(AW'(32'h1000), 31, 1'b1, br);
            rd_burst('0, 31, 1'b1);
        join
        rd_burst(AW'(32'h1000), 31, 1'b0);

        chk_en = 1'b0;
        @(posedge clk); #1;
        hp_awaddr  = AW'(32'h3000);
        hp_awlen   = 8'd200;
        hp_awvalid = 1'b1;
        hp_araddr  = '0;
        hp_arlen   = 8'd255;
        hp_arvalid = 1'b1;
        hp_rready  = 1'b1;
        hp_wstrb   = '1;
        hp_wlast   = 1'b0;
        hp_wvalid  = 1'b1;
        hp_wdata   = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            hs = hp_wvalid && hp_wready;
            @(posedge clk);
            if (hs) begin
                mdl[768 + n] = hp_wdata;
                n++;
            end
            #1;
            hp_awvalid = 1'b0;
            hp_arvalid = 1'b0;
            if (hs) hp_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
        #3 rstn = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        hp_wvalid = 1'b0;
        hp_rready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        chk_en = 1'b1;
        check("rst_beats_written", DW'(n), DW'(39));
        if (n > 0) rd_burst(AW'(32'h3000), n - 1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            wd[i] = {$urandom, $urandom, $urandom, $urandom};
            ws[i] = '1;
            wl[i] = (i == 3);
        end
        wr_burst(AW'(32'h2000), 3, 1'b0, br);
        rd_burst(AW'(32'h2000), 3, 1'b0);

        a = AW'(1) << (4 + DL);
        wd[0] = {$urandom, $urandom, $urandom, $urandom};
        ws[0] = '1;
        wl[0] = 1'b1;
        wr_burst(a, 0, 1'b0, br);
        check("model_range_bresp", DW'(br), RC ? DW'(3) : DW'(0));
        rd_burst(a, 0, 1'b0);
        rd_burst('0, 0, 1'b0);

        repeat (3) @(posedge clk);
        check("b_queue_empty", DW'(exp_b_q.size()), DW'(0));
        check("r_queue_empty", DW'(exp_rd_q.size()), DW'(0));
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
